native_mem_responder: RTL
=========================

// Module: native_mem_responder
// PURPOSE
//  Behavioural/synthesizable target for the DDR3 native user interface: the responder side that
//  memory_checker_native drives. Accepts wr_en/rd_addr_en commands, stores data in on-chip RAM,
//  and returns read data with fixed latency and busy back-pressure. Used to close the checker
//  loop without DdrCtrl/PHY (fast regression, bring-up). Single clock domain.
// PARAMETERS
//  DATA_WIDTH    128  data bus width, matches `WFIFO_WIDTH
//  DM_WIDTH      16   byte-mask width, DATA_WIDTH/8
//  ADDR_LSB      4    low address bits dropped to form the word index (byte address in)
//  DEPTH_LOG2    10   RAM depth = 2**DEPTH_LOG2 words
//  RD_LATENCY    4    cycles from read accept to earliest rd_valid (>=1)
//  OUT_DEPTH     8    read-return credits, must be >= RD_LATENCY
//  WR_STALL_EVERY 0   after N accepted writes, wr_busy high 1 cycle; 0 disables
// PORTS
//  clk          in   1           user clock
//  reset        in   1           synchronous, active-high
//  wr_busy      out  1           write command not accepted this cycle
//  wr_en        in   1           write command + data valid
//  wr_addr      in   32          byte address
//  wr_data      in   DATA_WIDTH  write data
//  wr_datamask  in   DM_WIDTH    1 = byte masked (not written)
//  wr_ack       out  1           one-cycle pulse per accepted write
//  rd_busy      out  1           read command not accepted this cycle
//  rd_addr_en   in   1           read command valid
//  rd_addr      in   32          byte address
//  rd_en        in   1           consumer ready for read data
//  rd_data      out  DATA_WIDTH  read data
//  rd_valid     out  1           rd_data valid; transfer when rd_valid && rd_en
//  addr_err     out  1           sticky: any command word index >= 2**DEPTH_LOG2
// BEHAVIOUR
//  - Reset: wr_busy=0, wr_ack=0, rd_busy=0, rd_valid=0, rd_data=0, addr_err=0, credits=OUT_DEPTH,
//    stall counter=0, pipeline/return FIFO emptied. RAM contents NOT cleared.
//  - Word index = addr[ADDR_LSB+DEPTH_LOG2-1:ADDR_LSB]; upper bits ignored (wrap) but any
//    nonzero addr[31:ADDR_LSB+DEPTH_LOG2] sets addr_err (sticky until reset).
//  - Write accept: wr_en && !wr_busy. RAM bytes with mask=0 updated at clock edge; wr_ack=1 next
//    cycle (latency 1). wr_en while wr_busy: ignored, no ack; initiator must hold.
//  - Stall: counter counts accepts; on reaching WR_STALL_EVERY, wr_busy=1 next cycle for exactly
//    one cycle, counter -> 0.
//  - Read accept: rd_addr_en && !rd_busy. Consumes one credit. Data captured in accept cycle
//    with same-cycle write forwarding (write-before-read, per byte honouring mask).
//  - Read pipe: RD_LATENCY-stage shift register of {valid,data}; exits into return FIFO
//    (OUT_DEPTH deep). rd_valid/rd_data = FIFO head (registered). Earliest rd_valid exactly
//    RD_LATENCY cycles after accept when FIFO empty and rd_en=1. Order preserved.
//  - Credits: -1 per read accept, +1 per transfer (rd_valid && rd_en); both in same cycle -> net 0.
//    rd_busy = (credits == 0), combinational from registered counter. Guarantees no FIFO overflow.
//  - rd_en=0: head held stable, rd_valid stays 1; pipe keeps draining into FIFO.
//  - Reset asserted mid-operation: in-flight reads and pending acks discarded, no rd_valid/
//    wr_ack after reset edge.
//  - States (read side): IDLE (credits==OUT_DEPTH, FIFO empty), ACTIVE, FULL (credits==0);
//    derived from counter, no separate FSM register.
// TESTING
//  - Write 0x1000 data=0x0123..EF mask=0, then read 0x1000 -> rd_valid after 4 cycles, same data.
//  - Write A=all 0xAA, then write A=all 0x55 mask=0x00FF -> read gives upper 8 bytes 0x55, lower 0xAA.
//  - Same-cycle wr/rd to 0x2000 (old 0, new 0xFF..) -> read returns 0xFF.. (forwarding).
//  - rd_en=0, issue 8 reads -> rd_busy=1 on 9th cycle, no reads lost; rd_en=1 -> 8 in-order returns.
//  - WR_STALL_EVERY=3, 6 back-to-back writes -> wr_busy 1 cycle after 3rd and 6th, 6 wr_acks total.
//  - Read 0x0100_0000 (DEPTH_LOG2=10) -> addr_err=1 sticky; reset mid-burst -> all outputs 0, no stale rd_valid.

Source files
------------

// File: rtl/native_mem_responder_if.sv
// Native DDR3 user-interface bundle between a command initiator (master) and the
// on-chip memory responder (slave).
interface native_mem_responder_if #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DM_WIDTH   = 16
);
    logic                  wr_busy;
    logic                  wr_en;
    logic [31:0]           wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DM_WIDTH-1:0]   wr_datamask;
    logic                  wr_ack;
    logic                  rd_busy;
    logic                  rd_addr_en;
    logic [31:0]           rd_addr;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  addr_err;

    modport master (
        input  wr_busy, wr_ack, rd_busy, rd_data, rd_valid, addr_err,
        output wr_en, wr_addr, wr_data, wr_datamask, rd_addr_en, rd_addr, rd_en
    );

    modport slave (
        output wr_busy, wr_ack, rd_busy, rd_data, rd_valid, addr_err,
        input  wr_en, wr_addr, wr_data, wr_datamask, rd_addr_en, rd_addr, rd_en
    );
endinterface

// File: rtl/native_mem_responder.sv
// On-chip RAM responder for the native DDR3 user interface: byte-masked writes with
// optional periodic stalls, fixed-latency reads with credit-based back-pressure.
module native_mem_responder #(
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned DM_WIDTH       = 16,
    parameter int unsigned ADDR_LSB       = 4,
    parameter int unsigned DEPTH_LOG2     = 10,
    parameter int unsigned RD_LATENCY     = 4,
    parameter int unsigned OUT_DEPTH      = 8,
    parameter int unsigned WR_STALL_EVERY = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    native_mem_responder_if.slave mem_if
);
    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned IDX_MSB = ADDR_LSB + DEPTH_LOG2 - 1;
    localparam int unsigned CRED_W  = $clog2(OUT_DEPTH + 1);
    localparam int unsigned PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned PIPE_N  = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;
    localparam int unsigned STALL_W = (WR_STALL_EVERY > 1) ? $clog2(WR_STALL_EVERY + 1) : 1;

    typedef enum logic [1:0] {RD_IDLE, RD_ACTIVE, RD_FULL} rdState_e;

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    logic                  wrBusy_q, wrBusy_d;
    logic                  wrAck_q;
    logic                  addrErr_q;
    logic [STALL_W-1:0]    stallCnt_q, stallCnt_d;
    logic [CRED_W-1:0]     credits_q, credits_d;
    logic [PIPE_N-1:0]     pipeValid_q;
    logic [DATA_WIDTH-1:0] pipeData_q [PIPE_N];
    logic [DATA_WIDTH-1:0] fifoMem_q [OUT_DEPTH];
    logic [PTR_W-1:0]      fifoRd_q, fifoWr_q;
    logic [CRED_W-1:0]     fifoCnt_q;
    logic                  rdValid_q;
    logic [DATA_WIDTH-1:0] rdData_q;

    logic [DEPTH_LOG2-1:0] wrIdx, rdIdx;
    logic                  wrOutOfRange, rdOutOfRange;
    logic                  wrAccept, rdAccept, rdPop;
    logic [DATA_WIDTH-1:0] captureData;
    logic                  exitValid;
    logic [DATA_WIDTH-1:0] exitData;
    logic                  headLoad, fifoPop, fifoPush, bypass;
    rdState_e              rdState;
    logic                  unusedLowBits;

    assign wrIdx         = mem_if.wr_addr[IDX_MSB:ADDR_LSB];
    assign rdIdx         = mem_if.rd_addr[IDX_MSB:ADDR_LSB];
    assign wrOutOfRange  = |mem_if.wr_addr[31:IDX_MSB+1];
    assign rdOutOfRange  = |mem_if.rd_addr[31:IDX_MSB+1];
    assign unusedLowBits = ^{mem_if.wr_addr[ADDR_LSB-1:0], mem_if.rd_addr[ADDR_LSB-1:0]};

    assign wrAccept = mem_if.wr_en && !wrBusy_q && !reset_i;
    assign rdAccept = mem_if.rd_addr_en && !mem_if.rd_busy && !reset_i;
    assign rdPop    = rdValid_q && mem_if.rd_en;

    // Read-side occupancy is inferred from the credit counter and the return path.
    always_comb begin
        if (credits_q == '0) begin
            rdState = RD_FULL;
        end else if (credits_q == CRED_W'(OUT_DEPTH) && !rdValid_q && fifoCnt_q == '0) begin
            rdState = RD_IDLE;
        end else begin
            rdState = RD_ACTIVE;
        end
    end

    // A same-cycle write to the read word wins, byte by byte, unless that byte is masked.
    always_comb begin
        captureData = ram[rdIdx];
        for (int b = 0; b < DM_WIDTH; b++) begin
            if (wrAccept && wrIdx == rdIdx && !mem_if.wr_datamask[b]) begin
                captureData[8*b +: 8] = mem_if.wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wrAccept) begin
            for (int b = 0; b < DM_WIDTH; b++) begin
                if (!mem_if.wr_datamask[b]) begin
                    ram[wrIdx][8*b +: 8] <= mem_if.wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        wrBusy_d   = 1'b0;
        if (wrAccept && WR_STALL_EVERY != 0) begin
            if (32'(stallCnt_q) + 32'd1 == WR_STALL_EVERY) begin
                stallCnt_d = '0;
                wrBusy_d   = 1'b1;
            end else begin
                stallCnt_d = stallCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrBusy_q   <= 1'b0;
            wrAck_q    <= 1'b0;
            stallCnt_q <= '0;
            addrErr_q  <= 1'b0;
        end else begin
            wrBusy_q   <= wrBusy_d;
            wrAck_q    <= wrAccept;
            stallCnt_q <= stallCnt_d;
            addrErr_q  <= addrErr_q | (wrAccept && wrOutOfRange) | (rdAccept && rdOutOfRange);
        end
    end

    assign credits_d = credits_q - CRED_W'(rdAccept) + CRED_W'(rdPop);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_q <= CRED_W'(OUT_DEPTH);
        end else begin
            credits_q <= credits_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pipeValid_q <= '0;
        end else begin
            pipeValid_q[0] <= rdAccept;
            for (int i = 1; i < PIPE_N; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
            end
        end
        pipeData_q[0] <= captureData;
        for (int i = 1; i < PIPE_N; i++) begin
            pipeData_q[i] <= pipeData_q[i-1];
        end
    end

    // The registered head adds one cycle, so the pipe is one stage shorter than the latency.
    generate
        if (RD_LATENCY == 1) begin : g_noPipe
            assign exitValid = rdAccept;
            assign exitData  = captureData;
        end else begin : g_pipe
            assign exitValid = pipeValid_q[PIPE_N-1];
            assign exitData  = pipeData_q[PIPE_N-1];
        end
    endgenerate

    always_comb begin
        headLoad = !rdValid_q || rdPop;
        fifoPop  = headLoad && fifoCnt_q != '0;
        bypass   = headLoad && fifoCnt_q == '0 && exitValid;
        fifoPush = exitValid && !bypass;
    end

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdValid_q <= 1'b0;
            rdData_q  <= '0;
            fifoRd_q  <= '0;
            fifoWr_q  <= '0;
            fifoCnt_q <= '0;
        end else begin
            if (fifoPop) begin
                rdValid_q <= 1'b1;
                rdData_q  <= fifoMem_q[fifoRd_q];
                fifoRd_q  <= ptrInc(fifoRd_q);
            end else if (bypass) begin
                rdValid_q <= 1'b1;
                rdData_q  <= exitData;
            end else if (rdPop) begin
                rdValid_q <= 1'b0;
            end
            if (fifoPush) begin
                fifoMem_q[fifoWr_q] <= exitData;
                fifoWr_q            <= ptrInc(fifoWr_q);
            end
            fifoCnt_q <= fifoCnt_q + CRED_W'(fifoPush) - CRED_W'(fifoPop);
        end
    end

    assign mem_if.wr_busy  = wrBusy_q;
    assign mem_if.wr_ack   = wrAck_q;
    assign mem_if.rd_busy  = (rdState == RD_FULL);
    assign mem_if.rd_valid = rdValid_q;
    assign mem_if.rd_data  = rdData_q;
    assign mem_if.addr_err = addrErr_q;
endmodule
